// File: rtl/if_id_fetch_ctrl.sv
// Fetch-stage controller: owns the PC and the IF/ID pipeline register. It applies
// hazard-unit stall/flush controls and EX redirects, and detects HALT to freeze fetch.
// It also keeps saturating stall/flush event counters for debug.
module if_id_fetch_ctrl #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_write_i,
   input  logic             if_id_write_i,
   input  logic             if_id_flush_i,
   input  logic             redirect_i,
   input  logic [15:0]      redirect_pc_i,
   input  logic [15:0]      imem_instr_i,
   output logic [15:0]      imem_addr_o,
   output logic [15:0]      id_instr_o,
   output logic [15:0]      id_pc2_o,
   output logic             id_valid_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [15:0]      pc_q, pc_d;
   logic [15:0]      instr_q, instr_d;
   logic [15:0]      pc2_q, pc2_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [15:0]      pc_plus2;
   logic             stall_inc, flush_inc;

   assign pc_plus2 = pc_q + 16'd2;

   // Next-state: redirect > flush > independent PC / IF/ID gating; HALT only honours redirect.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pc2_d     = pc2_q;
      valid_d   = valid_q;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      unique case (state_q)
         StRun: begin
            if (redirect_i) begin
               pc_d      = redirect_pc_i;
               instr_d   = NOP_INSTR;
               pc2_d     = 16'h0000;
               valid_d   = 1'b0;
               flush_inc = 1'b1;
            end else if (if_id_flush_i) begin
               // PC already points past the branch, i.e. the not-taken path.
               instr_d   = NOP_INSTR;
               pc2_d     = 16'h0000;
               valid_d   = 1'b0;
               flush_inc = 1'b1;
            end else begin
               if (pc_write_i) begin
                  pc_d = pc_plus2;
               end
               if (if_id_write_i) begin
                  instr_d = imem_instr_i;
                  pc2_d   = pc_plus2;
                  valid_d = 1'b1;
                  if (imem_instr_i[15:11] == 5'b00000) begin
                     // HALT freezes fetch at its own address.
                     state_d = StHalt;
                     pc_d    = pc_q;
                  end
               end else begin
                  stall_inc = 1'b1;
               end
            end
         end
         StHalt: begin
            if (redirect_i) begin
               state_d   = StRun;
               pc_d      = redirect_pc_i;
               instr_d   = NOP_INSTR;
               pc2_d     = 16'h0000;
               valid_d   = 1'b0;
               flush_inc = 1'b1;
            end else if (if_id_write_i) begin
               instr_d = NOP_INSTR;
               pc2_d   = 16'h0000;
               valid_d = 1'b0;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != CntMax)) begin
         stall_cnt_d = stall_cnt_q + CntOne;
      end
      if (flush_inc && (flush_cnt_q != CntMax)) begin
         flush_cnt_d = flush_cnt_q + CntOne;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StRun;
         pc_q        <= RESET_PC;
         instr_q     <= NOP_INSTR;
         pc2_q       <= 16'h0000;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         pc2_q       <= pc2_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign id_instr_o  = instr_q;
   assign id_pc2_o    = pc2_q;
   assign id_valid_o  = valid_q;
   assign halted_o    = (state_q == StHalt);
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// Directed table-driven bench for if_id_fetch_ctrl, plus a second instance with a
// wrapping reset PC and narrow counters to exercise wrap and saturation.
module tb_if_id_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b1, if_id_write = 1'b1, if_id_flush = 1'b0, redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        ovr_en = 1'b0;
   logic [15:0] ovr_val = 16'h0000;

   logic [15:0] a_addr, a_instr, a_pc2, a_imem;
   logic        a_valid, a_halted;
   logic [15:0] a_stall, a_flush;

   logic [15:0] b_addr, b_instr, b_pc2, b_imem;
   logic        b_valid, b_halted;
   logic [1:0]  b_stall, b_flush;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instruction memory models: word at addr reads 16'h4000 + addr unless overridden.
   always_comb begin
      a_imem = ovr_en ? ovr_val : (a_addr + 16'h4000);
      b_imem = b_addr + 16'h4000;
   end

   if_id_fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .pc_write_i    (pc_write),
      .if_id_write_i (if_id_write),
      .if_id_flush_i (if_id_flush),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_instr_i  (a_imem),
      .imem_addr_o   (a_addr),
      .id_instr_o    (a_instr),
      .id_pc2_o      (a_pc2),
      .id_valid_o    (a_valid),
      .halted_o      (a_halted),
      .stall_cnt_o   (a_stall),
      .flush_cnt_o   (a_flush)
   );

   if_id_fetch_ctrl #(
      .RESET_PC (16'hFFFE),
      .CNT_W    (2)
   ) dut_wrap (
      .clk           (clk),
      .rst           (rst),
      .pc_write_i    (pc_write),
      .if_id_write_i (if_id_write),
      .if_id_flush_i (if_id_flush),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_instr_i  (b_imem),
      .imem_addr_o   (b_addr),
      .id_instr_o    (b_instr),
      .id_pc2_o      (b_pc2),
      .id_valid_o    (b_valid),
      .halted_o      (b_halted),
      .stall_cnt_o   (b_stall),
      .flush_cnt_o   (b_flush)
   );

   typedef struct {
      logic        pw, iw, fl, rd;
      logic [15:0] rpc;
      logic        ov;
      logic [15:0] ovv;
      logic [15:0] e_addr, e_instr, e_pc2;
      logic        e_valid, e_halt;
      logic [15:0] e_stall, e_flush;
   } vec_t;

   localparam int NVec = 25;
   vec_t vecs[NVec];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_a(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                          input logic [15:0] pc2, input logic valid, input logic halt,
                          input logic [15:0] st, input logic [15:0] fl);
      check({tag, " addr"},   32'(a_addr),   32'(addr));
      check({tag, " instr"},  32'(a_instr),  32'(instr));
      check({tag, " pc2"},    32'(a_pc2),    32'(pc2));
      check({tag, " valid"},  32'(a_valid),  32'(valid));
      check({tag, " halted"}, 32'(a_halted), 32'(halt));
      check({tag, " stall"},  32'(a_stall),  32'(st));
      check({tag, " flush"},  32'(a_flush),  32'(fl));
   endtask

   task automatic drive(input logic pw, input logic iw, input logic fl, input logic rd,
                        input logic [15:0] rpc);
      pc_write    = pw;
      if_id_write = iw;
      if_id_flush = fl;
      redirect    = rd;
      redirect_pc = rpc;
   endtask

   function automatic vec_t mk(input logic pw, iw, fl, rd, input logic [15:0] rpc,
                               input logic ov, input logic [15:0] ovv,
                               input logic [15:0] ea, ei, ep, input logic ev, eh,
                               input logic [15:0] es, ef);
      vec_t v;
      v.pw = pw; v.iw = iw; v.fl = fl; v.rd = rd; v.rpc = rpc; v.ov = ov; v.ovv = ovv;
      v.e_addr = ea; v.e_instr = ei; v.e_pc2 = ep; v.e_valid = ev; v.e_halt = eh;
      v.e_stall = es; v.e_flush = ef;
      return v;
   endfunction

   initial begin
      // pw iw fl rd rpc ov ovv | addr instr pc2 valid halt stall flush (after the edge)
      vecs[0]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0002, 16'h4000, 16'h0002, 1, 0, 0, 0);
      vecs[1]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0, 0, 0);
      vecs[3]  = mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0, 1, 0);
      vecs[4]  = mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0, 2, 0);
      vecs[5]  = mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0, 3, 0);
      vecs[6]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0008, 16'h4006, 16'h0008, 1, 0, 3, 0);
      vecs[7]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h000A, 16'h4008, 16'h000A, 1, 0, 3, 0);
      vecs[8]  = mk(1, 1, 1, 0, 16'h0000, 0, 0, 16'h000A, 16'h0800, 16'h0000, 0, 0, 3, 1);
      vecs[9]  = mk(1, 1, 1, 0, 16'h0000, 0, 0, 16'h000A, 16'h0800, 16'h0000, 0, 0, 3, 2);
      vecs[10] = mk(1, 1, 0, 1, 16'h0040, 0, 0, 16'h0040, 16'h0800, 16'h0000, 0, 0, 3, 3);
      vecs[11] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0042, 16'h4040, 16'h0042, 1, 0, 3, 3);
      // redirect + flush + stall together: one bubble, one flush count, no stall count
      vecs[12] = mk(0, 0, 1, 1, 16'h0060, 0, 0, 16'h0060, 16'h0800, 16'h0000, 0, 0, 3, 4);
      // redirect_pc ignored without redirect
      vecs[13] = mk(1, 1, 0, 0, 16'h1234, 0, 0, 16'h0062, 16'h4060, 16'h0062, 1, 0, 3, 4);
      vecs[14] = mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0064, 16'h4060, 16'h0062, 1, 0, 4, 4);
      vecs[15] = mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0064, 16'h4064, 16'h0066, 1, 0, 4, 4);
      vecs[16] = mk(1, 1, 0, 1, 16'h0008, 0, 0, 16'h0008, 16'h0800, 16'h0000, 0, 0, 4, 5);
      // HALT fetched at pc 8
      vecs[17] = mk(1, 1, 0, 0, 16'h0000, 1, 0, 16'h0008, 16'h0000, 16'h000A, 1, 1, 4, 5);
      vecs[18] = mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0008, 16'h0000, 16'h000A, 1, 1, 4, 5);
      vecs[19] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0008, 16'h0800, 16'h0000, 0, 1, 4, 5);
      vecs[20] = mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0008, 16'h0800, 16'h0000, 0, 1, 4, 5);
      vecs[21] = mk(1, 1, 0, 1, 16'h0020, 0, 0, 16'h0020, 16'h0800, 16'h0000, 0, 0, 4, 6);
      vecs[22] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0022, 16'h4020, 16'h0022, 1, 0, 4, 6);
      // PC wrap
      vecs[23] = mk(1, 1, 0, 1, 16'hFFFE, 0, 0, 16'hFFFE, 16'h0800, 16'h0000, 0, 0, 4, 7);
      vecs[24] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h3FFE, 16'h0000, 1, 0, 4, 7);

      repeat (2) @(posedge clk);
      #1;
      check_a("reset", 16'h0000, 16'h0800, 16'h0000, 0, 0, 0, 0);
      check("wrap reset addr", 32'(b_addr), 32'h0000_FFFE);
      rst = 1'b0;

      for (int i = 0; i < NVec; i++) begin
         drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].rd, vecs[i].rpc);
         ovr_en  = vecs[i].ov;
         ovr_val = vecs[i].ovv;
         @(posedge clk);
         #1;
         check_a($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc2,
                 vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_stall, vecs[i].e_flush);
         if (i == 0) begin
            check("wrap v0 addr",  32'(b_addr),  32'h0000_0000);
            check("wrap v0 instr", 32'(b_instr), 32'h0000_3FFE);
            check("wrap v0 pc2",   32'(b_pc2),   32'h0000_0000);
            check("wrap v0 valid", 32'(b_valid), 32'h1);
         end
      end
      ovr_en = 1'b0;
      check("sat stall", 32'(b_stall), 32'h3);
      check("sat flush", 32'(b_flush), 32'h3);
      check("wrap halted", 32'(b_halted), 32'h0);

      // Stall two cycles, then pulse reset between clock edges.
      drive(0, 0, 0, 0, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      check_a("stall2", 16'h0000, 16'h3FFE, 16'h0000, 1, 0, 6, 7);
      #2 rst = 1'b1;
      #1;
      check_a("async rst", 16'h0000, 16'h0800, 16'h0000, 0, 0, 0, 0);
      check("async rst wrap stall", 32'(b_stall), 32'h0);
      check("async rst wrap addr",  32'(b_addr),  32'h0000_FFFE);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1, 0, 0, 16'h0000);
      @(posedge clk);
      #1;
      check_a("post rst", 16'h0002, 16'h4000, 16'h0002, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_id_fetch_ctrl.md
Name: if_id_fetch_ctrl

Overview:
Fetch-stage controller that consumes the pipeline hazard unit's control outputs (PCWrite, IF_ID_Write, IF_ID_Flush) and branch redirects from EX. It owns the PC register and the IF/ID pipeline register, and presents fetched instructions to decode. It also detects HALT, freezing fetch until a redirect arrives, and keeps saturating stall and flush event counters for debug.

Parameters:
RESET_PC, 16'h0000, PC value loaded at reset
NOP_INSTR, 16'h0800, encoding (opcode 00001) inserted into IF/ID on flush, redirect, reset and halt
CNT_W, 16, width of stall and flush counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pc_write_i  input  1  hazard unit PCWrite; 0 holds PC
if_id_write_i  input  1  hazard unit IF_ID_Write; 0 holds IF/ID
if_id_flush_i  input  1  hazard unit IF_ID_Flush; control instruction in ID or EX
redirect_i  input  1  taken branch/jump resolved in EX
redirect_pc_i  input  16  redirect target
imem_instr_i  input  16  instruction memory read data for imem_addr_o, valid same cycle
imem_addr_o  output  16  current PC, driven directly from PC register
id_instr_o  output  16  IF/ID instruction
id_pc2_o  output  16  IF/ID PC+2 of that instruction
id_valid_o  output  1  IF/ID holds a real fetched instruction
halted_o  output  1  state == HALT
stall_cnt_o  output  CNT_W  saturating stall-cycle count
flush_cnt_o  output  CNT_W  saturating bubble-insert count

Behaviour:
- Reset (async, any time, including mid-stall or mid-flush):
  - pc = RESET_PC; state = RUN.
  - id_instr_o = NOP_INSTR; id_pc2_o = 0; id_valid_o = 0; halted_o = 0; both counters = 0.
- States: RUN, HALT.
- Per-cycle priority in RUN, highest first:
  - 1. redirect_i:
    - pc <= redirect_pc_i.
    - IF/ID <= {NOP_INSTR, 0, valid 0}.
    - flush_cnt +1.
  - 2. if_id_flush_i:
    - pc held (points to branch+2, which is correct for a not-taken branch).
    - IF/ID <= NOP bubble, valid 0.
    - flush_cnt +1.
  - 3. Otherwise, each control is gated independently:
    - PC: pc <= pc+2 if pc_write_i=1, else held.
    - IF/ID: if if_id_write_i=1, load {imem_instr_i, pc+2, valid 1}; else hold all three fields.
    - stall_cnt +1 when if_id_write_i=0.
- HALT detect:
  - Condition: in RUN, case 3 loads IF/ID with imem_instr_i[15:11]==5'b00000.
  - Result: state -> HALT on the same edge. The HALT instruction itself is latched, valid 1.
- HALT state:
  - pc frozen.
  - IF/ID holds its contents while if_id_write_i=0; otherwise loads NOP bubble, valid 0.
  - Flush and stall inputs do not advance the pc.
  - Counters increment only on redirect.
  - redirect_i: HALT was speculative; pc <= redirect_pc_i, IF/ID <= bubble, state -> RUN, flush_cnt +1.
- PC arithmetic is 16-bit and wraps: 16'hFFFE + 2 = 16'h0000. id_pc2_o wraps identically.
- Counters saturate at all-ones and never wrap.
- Latency:
  - Fetched instruction appears on id_instr_o one cycle after its address is on imem_addr_o.
  - Redirect target appears on imem_addr_o the cycle after redirect_i.
- redirect_pc_i is ignored when redirect_i=0.
- Simultaneous redirect_i and if_id_flush_i: redirect wins, and flush_cnt counts once.
- Simultaneous redirect_i with pc_write_i=0 (stall): redirect wins.

Test Plan:
- Reset then free-run, all controls 1, imem returns 16'h4000+addr: imem_addr_o sequence 0,2,4. id_instr_o = 16'h4000 at cycle 1 with id_pc2_o=2 and id_valid_o=1.
- pc_write_i=if_id_write_i=0 for 3 cycles at pc=6: imem_addr_o stays 6 and IF/ID stays unchanged. stall_cnt_o=3, then fetch resumes at 8.
- if_id_flush_i=1 for 2 cycles at pc=10, then redirect_i=1 with redirect_pc_i=16'h0040: IF/ID shows NOP_INSTR with valid 0 for 3 cycles. imem_addr_o goes 10,10,10,16'h0040. flush_cnt_o=3.
- Same cycle redirect_i=1 and if_id_flush_i=1: single bubble, flush_cnt_o increments by exactly 1.
- imem returns 16'h0000 at pc=8: id_instr_o=0 with valid 1, halted_o=1, pc frozen at 8, followed by NOP bubbles. A later redirect to 16'h0020 clears halted_o and fetch resumes at 16'h0020.
- Wrap and reset: RESET_PC=16'hFFFE fetch goes to 0 with id_pc2_o=0. Async rst pulsed mid-stall clears all outputs and counters immediately, without waiting for a clock edge.
